alu_issue_ctrl: RTL and testbench
=================================

// Module: alu_issue_ctrl
// PURPOSE
//  Command front end for the ALU; sits directly upstream of the LOGIC_UNIT and its sibling units.
//  - Accepts one operation at a time over a valid/ready handshake.
//  - Decodes the 4-bit function: FUN[3:2] selects the unit, FUN[1:0] is the op.
//  - Pulses exactly one unit enable for one cycle, then waits for that unit's registered flag.
//  - Captures the result and holds it on a valid/ready response port.
// PARAMETERS
//  width       16  operand and result width
//  TIMEOUT_CYC 8   WAIT-state cycle limit; used only when ALU_ISSUE_TIMEOUT_EN is defined
// PORTS
//  CLK           in   1      clock, rising edge
//  RST           in   1      asynchronous active-low reset
//  cmd_valid     in   1      command present
//  cmd_ready     out  1      command accepted when cmd_valid && cmd_ready
//  cmd_a         in   width  operand A
//  cmd_b         in   width  operand B
//  cmd_fun       in   4      [3:2] unit select (00 arith, 01 logic, 10 cmp, 11 shift); [1:0] op
//  A, B          out  width  operands driven to the units
//  ALU_FUN       out  2      unit op code (cmd_fun[1:0])
//  Arith_Enable  out  1      one-cycle enable, arith unit
//  Logic_Enable  out  1      one-cycle enable, logic unit
//  CMP_Enable    out  1      one-cycle enable, compare unit
//  Shift_Enable  out  1      one-cycle enable, shift unit
//  Arith_OUT, Logic_OUT, CMP_OUT, Shift_OUT  in  width  registered unit results
//  Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag  in  1  registered unit valid flags
//  rsp_valid     out  1      response held
//  rsp_ready     in   1      response consumed when rsp_valid && rsp_ready
//  rsp_data      out  width  captured result
//  rsp_unit      out  2      unit that produced rsp_data
//  rsp_err       out  1      timeout response (tied 0 when the macro is absent)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, operand and result registers cleared; takes effect immediately.
//  Clock and reset: single clock CLK; RST is asynchronous, active-low.
//  FSM (registered state): IDLE -> ISSUE -> WAIT -> HOLD -> IDLE.
//  IDLE
//   - cmd_ready=1.
//   - On handshake (cycle T), register cmd_a, cmd_b, cmd_fun; go to ISSUE.
//  ISSUE (T+1)
//   - Drive A, B, ALU_FUN from registers.
//   - Exactly one enable=1, per FUN[3:2]; others 0.
//   - Go to WAIT unconditionally.
//  WAIT (T+2 onward)
//   - All enables 0; A, B, ALU_FUN held stable.
//   - Watch only the selected unit's flag.
//   - Flag=1: capture the selected *_OUT into rsp_data (same edge), rsp_unit=FUN[3:2]; go to HOLD.
//   - Capture must happen in the flag cycle; the unit clears its output on the next edge.
//   - Flags from non-selected units are ignored.
//  HOLD (>= T+3)
//   - rsp_valid=1; rsp_data, rsp_unit, rsp_err stable until rsp_ready.
//   - On handshake, go to IDLE with rsp_valid=0 the next cycle.
//  Throughput and latency
//   - Minimum 4 cycles per op; accept-to-rsp_valid latency is exactly 3 cycles when the flag returns on time.
//   - cmd_ready=0 outside IDLE; commands presented then are not consumed and must stay asserted.
//  Boundary cases
//   - rsp_ready already high at first rsp_valid: completes in 1 HOLD cycle.
//   - Reset mid-op: op dropped, no response.
// CONFIGURATION
//  ALU_ISSUE_TIMEOUT_EN defined
//   - Counter runs in WAIT.
//   - After TIMEOUT_CYC cycles with no flag: go to HOLD with rsp_data=0, rsp_err=1, rsp_unit=selected.
//  ALU_ISSUE_TIMEOUT_EN undefined
//   - WAIT persists until the flag arrives; rsp_err constant 0; no counter logic.
// STRUCTURE
//  alu_pkg (shared)
//   - Unit-select localparams: UNIT_ARITH=2'b00, UNIT_LOGIC=2'b01, UNIT_CMP=2'b10, UNIT_SHIFT=2'b11.
//   - FSM state encodings; FUN_W=4.
//  Sub-module alu_fun_decode (combinational)
//   - Inputs: unit select, issue strobe.
//   - Outputs: the four one-hot enables.
//  All other logic stays in alu_issue_ctrl.
// TESTING
//  1 Reset: RST=0 mid-WAIT -> all outputs 0 at once; after release cmd_ready=1; no rsp_valid.
//  2 AND via logic unit: a=16'hF0F0, b=16'hFF00, fun=4'b0100
//    -> Logic_Enable high one cycle at T+1; rsp_valid at T+3; rsp_data=16'hF000, rsp_unit=01.
//  3 NOR back-to-back with rsp_ready=0 for 5 cycles: a=16'h0001, b=16'h0002, fun=4'b0111
//    -> rsp_data=16'hFFFC held stable; cmd_ready=0 throughout; next cmd accepted only after rsp handshake.
//  4 Unit select: each FUN[3:2] value -> only the matching enable pulses; spurious non-selected flag in WAIT ignored.
//  5 Timeout (macro on, TIMEOUT_CYC=8): selected flag never asserts
//    -> rsp_valid at T+2+8+1, rsp_err=1, rsp_data=0; macro off -> FSM stays in WAIT.
//  6 Handshake stress: random cmd_valid/rsp_ready -> every accepted command yields exactly one response, in order.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: unit-select codes, function width and issue FSM encoding shared by the ALU front end
package alu_pkg;
  localparam int FUN_W = 4;
  localparam logic [1:0] UNIT_ARITH = 2'b00;
  localparam logic [1:0] UNIT_LOGIC = 2'b01;
  localparam logic [1:0] UNIT_CMP   = 2'b10;
  localparam logic [1:0] UNIT_SHIFT = 2'b11;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;
endpackage

// File: rtl/alu_fun_decode.sv
// alu_fun_decode: one-hot unit enables from the unit select, gated by the issue strobe
module alu_fun_decode
  import alu_pkg::*;
(
  input  logic [1:0] unit,
  input  logic       issue,
  output logic       arith_en,
  output logic       logic_en,
  output logic       cmp_en,
  output logic       shift_en
);
  assign arith_en = issue && unit == UNIT_ARITH;
  assign logic_en = issue && unit == UNIT_LOGIC;
  assign cmp_en   = issue && unit == UNIT_CMP;
  assign shift_en = issue && unit == UNIT_SHIFT;
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: valid/ready command front end that issues one op to an ALU unit and holds its result.
// Optional WAIT timeout (error response) enabled by defining ALU_ISSUE_TIMEOUT_EN.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int width       = 16,
  parameter int TIMEOUT_CYC = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [width-1:0] cmd_a,
  input  logic [width-1:0] cmd_b,
  input  logic [FUN_W-1:0] cmd_fun,
  output logic [width-1:0] A,
  output logic [width-1:0] B,
  output logic [1:0]       ALU_FUN,
  output logic             Arith_Enable,
  output logic             Logic_Enable,
  output logic             CMP_Enable,
  output logic             Shift_Enable,
  input  logic [width-1:0] Arith_OUT,
  input  logic [width-1:0] Logic_OUT,
  input  logic [width-1:0] CMP_OUT,
  input  logic [width-1:0] Shift_OUT,
  input  logic             Arith_Flag,
  input  logic             Logic_Flag,
  input  logic             CMP_Flag,
  input  logic             Shift_Flag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [width-1:0] rsp_data,
  output logic [1:0]       rsp_unit,
  output logic             rsp_err
);
  state_t state, state_nx;
  logic [1:0] unit;
  logic flag, tmo, cap;
  logic [width-1:0] out_sel;
  always_comb begin
    flag = unit == UNIT_ARITH ? Arith_Flag : unit == UNIT_LOGIC ? Logic_Flag :
           unit == UNIT_CMP ? CMP_Flag : Shift_Flag;
    out_sel = unit == UNIT_ARITH ? Arith_OUT : unit == UNIT_LOGIC ? Logic_OUT :
              unit == UNIT_CMP ? CMP_OUT : Shift_OUT;
  end
  // cmd_ready is masked by reset so every output reads 0 while RST is low
  assign cmd_ready = RST && state == S_IDLE;
  assign rsp_valid = state == S_HOLD;
  assign cap = state == S_WAIT && (flag || tmo);
  always_comb begin
    state_nx = state == S_IDLE ? (cmd_valid ? S_ISSUE : S_IDLE) :
               state == S_ISSUE ? S_WAIT :
               state == S_WAIT ? (cap ? S_HOLD : S_WAIT) :
               (rsp_ready ? S_IDLE : S_HOLD);
  end
  always_ff @(posedge CLK or negedge RST)
    if (!RST) state <= S_IDLE;
    else state <= state_nx;
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      A <= '0;
      B <= '0;
      ALU_FUN <= '0;
      unit <= '0;
      rsp_data <= '0;
      rsp_unit <= '0;
    end else begin
      if (cmd_valid && cmd_ready) begin
        A <= cmd_a;
        B <= cmd_b;
        ALU_FUN <= cmd_fun[1:0];
        unit <= cmd_fun[3:2];
      end
      if (cap) begin
        rsp_data <= flag ? out_sel : '0;
        rsp_unit <= unit;
      end
    end
`ifdef ALU_ISSUE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt;
  assign tmo = cnt == CW'(TIMEOUT_CYC);
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      cnt <= '0;
      rsp_err <= 1'b0;
    end else begin
      cnt <= state == S_WAIT ? cnt + 1'b1 : '0;
      if (cap) rsp_err <= !flag;
    end
`else
  assign tmo = 1'b0;
  assign rsp_err = 1'b0;
`endif
  alu_fun_decode u_dec (
    .unit(unit),
    .issue(state == S_ISSUE),
    .arith_en(Arith_Enable),
    .logic_en(Logic_Enable),
    .cmp_en(CMP_Enable),
    .shift_en(Shift_Enable)
  );
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed + random bench for alu_issue_ctrl with behavioural unit models and a
// transaction-level scoreboard (accept time, expected result, expected latency) checked every cycle.
module tb_alu_issue_ctrl;
  localparam int TO = 8;
  logic CLK = 0, RST = 0;
  logic cmd_valid = 0, rsp_ready = 0;
  logic [15:0] cmd_a = 0, cmd_b = 0;
  logic [3:0] cmd_fun = 0;
  logic [15:0] A, B, rsp_data;
  logic [1:0] ALU_FUN, rsp_unit;
  logic Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable;
  logic cmd_ready, rsp_valid, rsp_err;
  logic [3:0] fl = 0;
  logic [15:0] uo [4];
  int errors = 0, checks = 0;
  int delay = 0, cur_delay = 0;
  logic mute = 0, cur_mute = 0;
  logic [3:0] spur_mask = 0;
  always #5 CLK = ~CLK;

  alu_issue_ctrl #(.width(16), .TIMEOUT_CYC(TO)) dut (
    .CLK(CLK), .RST(RST), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_fun(cmd_fun),
    .A(A), .B(B), .ALU_FUN(ALU_FUN),
    .Arith_Enable(Arith_Enable), .Logic_Enable(Logic_Enable),
    .CMP_Enable(CMP_Enable), .Shift_Enable(Shift_Enable),
    .Arith_OUT(uo[0]), .Logic_OUT(uo[1]), .CMP_OUT(uo[2]), .Shift_OUT(uo[3]),
    .Arith_Flag(fl[0]), .Logic_Flag(fl[1]), .CMP_Flag(fl[2]), .Shift_Flag(fl[3]),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_unit(rsp_unit), .rsp_err(rsp_err)
  );

  function automatic logic [15:0] alu_fn(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
    case (f)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return a + 16'd1;
      4'h3: return b - a;
      4'h4: return a & b;
      4'h5: return a | b;
      4'h6: return a ^ b;
      4'h7: return ~(a | b);
      4'h8: return {15'd0, a == b};
      4'h9: return {15'd0, a > b};
      4'hA: return {15'd0, a < b};
      4'hB: return {15'd0, a != b};
      4'hC: return a << b[3:0];
      4'hD: return a >> b[3:0];
      4'hE: return {a[14:0], a[15]};
      default: return {a[0], a[15:1]};
    endcase
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  // Registered unit models: flag and result appear 1+cur_delay cycles after the enable, for one cycle only
  initial begin
    int cd;
    logic [1:0] uu;
    logic [15:0] ures;
    logic [3:0] en;
    cd = 0; uu = 0; ures = 0;
    for (int i = 0; i < 4; i++) uo[i] = 16'hBAD0;
    forever begin
      @(negedge CLK);
      fl = spur_mask;
      for (int i = 0; i < 4; i++) uo[i] = 16'hBAD0 + 16'(i);
      if (!RST) begin
        cd = 0;
        fl = 0;
      end else begin
        if (cd > 0) begin
          cd--;
          if (cd == 0 && !cur_mute) begin
            fl[uu] = 1;
            uo[uu] = ures;
          end
        end
        en = {Shift_Enable, CMP_Enable, Logic_Enable, Arith_Enable};
        if (en != 0) begin
          uu = en[3] ? 2'd3 : en[2] ? 2'd2 : en[1] ? 2'd1 : 2'd0;
          ures = alu_fn({uu, ALU_FUN}, A, B);
          cd = 1 + cur_delay;
        end
      end
    end
  end

  // Scoreboard: one op in flight; expectations follow from accept cycle, command and latency
  int cyc = 0, acc_cyc = 0, lat = 0, n_acc = 0, n_rsp = 0;
  logic busy = 0, eerr = 0;
  logic [15:0] ea = 0, eb = 0, edata = 0;
  logic [3:0] efun = 0;
  initial forever begin
    @(negedge CLK);
    cyc++;
    if (!RST) busy = 0;
    else begin
      chk("cmd_ready", cmd_ready, !busy);
      chk("enables", {Shift_Enable, CMP_Enable, Logic_Enable, Arith_Enable},
          (busy && cyc - acc_cyc == 1) ? (4'b0001 << efun[3:2]) : 4'b0000);
      chk("rsp_valid", rsp_valid, busy && cyc - acc_cyc >= lat);
      if (busy) begin
        chk("A", A, ea);
        chk("B", B, eb);
        chk("ALU_FUN", ALU_FUN, efun[1:0]);
      end
      if (busy && rsp_valid) begin
        chk("rsp_data", rsp_data, edata);
        chk("rsp_unit", rsp_unit, efun[3:2]);
        chk("rsp_err", rsp_err, eerr);
      end
      if (busy && rsp_valid && rsp_ready) begin
        busy = 0;
        n_rsp++;
      end else if (!busy && cmd_valid && cmd_ready) begin
        busy = 1; acc_cyc = cyc; n_acc++;
        ea = cmd_a; eb = cmd_b; efun = cmd_fun;
        cur_delay = delay; cur_mute = mute;
        if (mute) begin
          edata = 0; eerr = 1;
`ifdef ALU_ISSUE_TIMEOUT_EN
          lat = 3 + TO;
`else
          lat = 1 << 30;
`endif
        end else begin
          edata = alu_fn(cmd_fun, cmd_a, cmd_b); eerr = 0; lat = 3 + delay;
        end
      end
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [3:0] f);
    int n;
    @(posedge CLK); #1;
    cmd_valid = 1; cmd_a = a; cmd_b = b; cmd_fun = f;
    n = 0;
    do begin @(negedge CLK); n++; end while (!cmd_ready && n < 100);
    if (!cmd_ready) chk("send timeout", 0, 1);
    @(posedge CLK); #1;
    cmd_valid = 0;
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    do begin @(negedge CLK); n++; end while (!rsp_valid && n < 100);
    if (!rsp_valid) chk("rsp timeout", 0, 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin @(negedge CLK); n++; end while (!cmd_ready && n < 100);
    if (!cmd_ready) chk("idle timeout", 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // reset state
    #12;
    chk("reset cmd_ready", cmd_ready, 0);
    chk("reset rsp_valid", rsp_valid, 0);
    @(posedge CLK); #1 RST = 1;
    @(negedge CLK);
    chk("post-reset cmd_ready", cmd_ready, 1);
    rsp_ready = 1;
    // AND via logic unit
    send(16'hF0F0, 16'hFF00, 4'b0100);
    wait_rsp();
    chk("AND data", rsp_data, 16'hF000);
    chk("AND unit", rsp_unit, 2'b01);
    wait_idle();
    // NOR held under backpressure with a second command waiting
    rsp_ready = 0;
    send(16'h0001, 16'h0002, 4'b0111);
    cmd_valid = 1; cmd_a = 16'h0005; cmd_b = 16'h0003; cmd_fun = 4'b0001;
    wait_rsp();
    repeat (5) begin
      @(negedge CLK);
      chk("NOR held data", rsp_data, 16'hFFFC);
      chk("NOR busy cmd_ready", cmd_ready, 0);
    end
    @(posedge CLK); #1 rsp_ready = 1;
    wait_idle();
    @(posedge CLK); #1 cmd_valid = 0;
    wait_rsp();
    chk("SUB data", rsp_data, 16'h0002);
    wait_idle();
    // every unit select, with spurious flags from the other units while waiting
    delay = 2;
    for (int u = 0; u < 4; u++) begin
      spur_mask = 4'hF & ~(4'b0001 << u);
      send(16'h1234 + 16'(u), 16'h0003, {2'(u), 2'(u)});
      wait_idle();
    end
    spur_mask = 0;
    delay = 0;
    send(16'h00A5, 16'h00A5, 4'b1000);
    wait_rsp();
    chk("CMP eq data", rsp_data, 16'h0001);
    wait_idle();
    // missing flag
    mute = 1;
`ifdef ALU_ISSUE_TIMEOUT_EN
    send(16'h7777, 16'h1111, 4'b1001);
    wait_rsp();
    chk("timeout err", rsp_err, 1);
    chk("timeout data", rsp_data, 0);
    chk("timeout unit", rsp_unit, 2'b10);
    wait_idle();
`endif
    send(16'h5A5A, 16'hA5A5, 4'b1101);
`ifdef ALU_ISSUE_TIMEOUT_EN
    repeat (6) @(negedge CLK);
`else
    repeat (30) @(negedge CLK);
`endif
    // asynchronous reset while waiting
    @(posedge CLK); #2 RST = 0;
    #1;
    chk("rst cmd_ready", cmd_ready, 0);
    chk("rst enables", {Shift_Enable, CMP_Enable, Logic_Enable, Arith_Enable}, 0);
    chk("rst A", A, 0);
    chk("rst B", B, 0);
    chk("rst ALU_FUN", ALU_FUN, 0);
    chk("rst rsp_valid", rsp_valid, 0);
    chk("rst rsp_data", rsp_data, 0);
    chk("rst rsp_unit", rsp_unit, 0);
    chk("rst rsp_err", rsp_err, 0);
    mute = 0;
    repeat (2) @(negedge CLK);
    @(posedge CLK); #1 RST = 1;
    @(negedge CLK);
    chk("release cmd_ready", cmd_ready, 1);
    repeat (5) begin
      @(negedge CLK);
      chk("no stale rsp", rsp_valid, 0);
    end
    // random handshake stress
    begin
      int n0, a0;
      logic hs;
      n0 = n_rsp; a0 = n_acc;
      for (int c = 0; c < 3000 && n_rsp - n0 < 40; c++) begin
        @(negedge CLK);
        hs = cmd_valid && cmd_ready;
        @(posedge CLK); #1;
        if (hs) cmd_valid = 0;
        if (!cmd_valid && $urandom_range(0, 1) == 1) begin
          cmd_valid = 1;
          cmd_a = 16'($urandom);
          cmd_b = 16'($urandom);
          cmd_fun = 4'($urandom);
          delay = $urandom_range(0, 3);
        end
        rsp_ready = $urandom_range(0, 1) == 1;
      end
      @(negedge CLK);
      hs = cmd_valid && cmd_ready;
      @(posedge CLK); #1;
      cmd_valid = 0;
      rsp_ready = 1;
      wait_idle();
      chk("stress count reached", (n_rsp - n0) >= 40, 1);
      chk("stress one rsp per cmd", n_rsp - n0, n_acc - a0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
